// File: rtl/i2s_tx_sched.sv
// Transmit scheduler that shares one I2S transmitter between NUM_SRC stereo producers.
// Ownership is granted per L/R frame; gaps are filled with silence and counted as underruns.
module i2s_tx_sched #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            mode_i,
  input  logic [NUM_SRC-1:0]              src_en_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  input  logic [NUM_SRC*2*DATA_WIDTH-1:0] src_data_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  input  logic                            tx_req_i,
  input  logic                            tx_lr_i,
  output logic [DATA_WIDTH-1:0]           tx_dat_o,
  output logic                            tx_vld_o,
  output logic [NUM_SRC-1:0]              grant_o,
  output logic                            busy_o,
  output logic [CNT_WIDTH-1:0]            udr_cnt_o,
  input  logic                            udr_clr_i
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_R = 2'd1,
    HOLD_Z = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [IW-1:0]           r_rr, w_rr_nxt;
  logic [DATA_WIDTH-1:0]   r_right, w_right_nxt;
  logic [DATA_WIDTH-1:0]   r_tx_dat, w_tx_dat_nxt;
  logic                    r_tx_vld, w_tx_vld_nxt;
  logic [NUM_SRC-1:0]      r_grant, w_grant_nxt;
  logic [CNT_WIDTH-1:0]    r_udr, w_udr_nxt;

  logic [NUM_SRC-1:0]      w_elig;
  logic                    w_any;
  logic [IW-1:0]           w_win;
  logic [NUM_SRC-1:0]      w_onehot;
  logic [2*DATA_WIDTH-1:0] w_frame;
  logic [NUM_SRC-1:0]      w_ready;
  logic [1:0]              w_inc;
  logic [CNT_WIDTH+1:0]    w_sum;

  assign w_elig = src_en_i & src_valid_i;

  // Fixed priority scans from index 0; round-robin scans cyclically from the rr pointer.
  always_comb begin : arb
    int            idx;
    logic [IW-1:0] idx_n;
    w_any = 1'b0;
    w_win = '0;
    idx   = 0;
    idx_n = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (mode_i) begin
        idx = k;
      end else begin
        idx = int'(r_rr) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      end
      idx_n = IW'(idx);
      if (!w_any && w_elig[idx_n]) begin
        w_any = 1'b1;
        w_win = idx_n;
      end
    end
  end

  always_comb begin
    w_frame  = '0;
    w_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_onehot[i] = (w_win == IW'(i));
      if (w_win == IW'(i)) w_frame = src_data_i[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr;
    w_right_nxt  = r_right;
    w_tx_dat_nxt = r_tx_dat;
    w_tx_vld_nxt = 1'b0;
    w_grant_nxt  = r_grant;
    w_ready      = '0;
    w_inc        = 2'd0;
    if (!en_i) begin
      // Disabled: any held frame is dropped and requests get silence without counting.
      w_state_nxt = IDLE;
      w_grant_nxt = '0;
      if (tx_req_i) begin
        w_tx_vld_nxt = 1'b1;
        w_tx_dat_nxt = '0;
      end
    end else if (tx_req_i) begin
      w_tx_vld_nxt = 1'b1;
      if (!tx_lr_i) begin
        // A left request while still holding a right word means the right slot was missed.
        if (r_state == HOLD_R) w_inc = 2'd1;
        if (w_any) begin
          w_ready[w_win] = 1'b1;
          w_right_nxt    = w_frame[2*DATA_WIDTH-1:DATA_WIDTH];
          w_tx_dat_nxt   = w_frame[DATA_WIDTH-1:0];
          w_grant_nxt    = w_onehot;
          w_rr_nxt       = (w_win == IW'(NUM_SRC - 1)) ? '0 : w_win + IW'(1);
          w_state_nxt    = HOLD_R;
        end else begin
          w_tx_dat_nxt = '0;
          w_grant_nxt  = '0;
          w_inc        = w_inc + 2'd1;
          w_state_nxt  = HOLD_Z;
        end
      end else begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
        case (r_state)
          HOLD_R:  w_tx_dat_nxt = r_right;
          HOLD_Z:  w_tx_dat_nxt = '0;
          default: begin
            w_tx_dat_nxt = '0;
            w_inc        = 2'd1;
          end
        endcase
      end
    end
  end

  // Saturating counter; a clear coincident with an increment keeps only the new events.
  always_comb begin
    w_sum = {2'b00, r_udr} + {{CNT_WIDTH{1'b0}}, w_inc};
    if (udr_clr_i) begin
      w_udr_nxt = CNT_WIDTH'(w_inc);
    end else if (w_sum[CNT_WIDTH+1:CNT_WIDTH] != 2'b00) begin
      w_udr_nxt = '1;
    end else begin
      w_udr_nxt = w_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rr     <= '0;
      r_right  <= '0;
      r_tx_dat <= '0;
      r_tx_vld <= 1'b0;
      r_grant  <= '0;
      r_udr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr     <= w_rr_nxt;
      r_right  <= w_right_nxt;
      r_tx_dat <= w_tx_dat_nxt;
      r_tx_vld <= w_tx_vld_nxt;
      r_grant  <= w_grant_nxt;
      r_udr    <= w_udr_nxt;
    end
  end

  // The accept pulse is suppressed during reset so no frame is consumed unanswered.
  assign src_ready_o = rst_i ? '0 : w_ready;
  assign tx_dat_o    = r_tx_dat;
  assign tx_vld_o    = r_tx_vld;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == HOLD_R);
  assign udr_cnt_o   = r_udr;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Scoreboard bench for i2s_tx_sched: requests push expected words, a monitor pops them
// on every tx_vld_o pulse and checks data and one-cycle latency.
module tb_i2s_tx_sched;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic         mode_i;
  logic [1:0]   src_en_i;
  logic [1:0]   src_valid_i;
  logic [127:0] src_data_i;
  logic [1:0]   src_ready_o;
  logic         tx_req_i;
  logic         tx_lr_i;
  logic [31:0]  tx_dat_o;
  logic         tx_vld_o;
  logic [1:0]   grant_o;
  logic         busy_o;
  logic [3:0]   udr_cnt_o;
  logic         udr_clr_i;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbQ[$];
  int   testCount = 0;
  int   failCount = 0;
  int   cycCount  = 0;

  localparam logic [31:0] S0L = 32'h11111111;
  localparam logic [31:0] S0R = 32'h22222222;
  localparam logic [31:0] S1L = 32'hAAAA0001;
  localparam logic [31:0] S1R = 32'hAAAA0002;

  i2s_tx_sched #(
    .NUM_SRC   (2),
    .DATA_WIDTH(32),
    .CNT_WIDTH (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .mode_i     (mode_i),
    .src_en_i   (src_en_i),
    .src_valid_i(src_valid_i),
    .src_data_i (src_data_i),
    .src_ready_o(src_ready_o),
    .tx_req_i   (tx_req_i),
    .tx_lr_i    (tx_lr_i),
    .tx_dat_o   (tx_dat_o),
    .tx_vld_o   (tx_vld_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .udr_cnt_o  (udr_cnt_o),
    .udr_clr_i  (udr_clr_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycCount++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycCount);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (tx_vld_o) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_vld", 64'(tx_dat_o), 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("tx_dat", 64'(tx_dat_o), 64'(e.data));
        checkOutput("latency", 64'(cycCount), 64'(e.due));
      end
    end
  end

  // One request pulse followed by one idle cycle; grant is checked in the response cycle.
  task automatic applyStimulus(input logic lr, input logic [31:0] expData,
                               input logic [1:0] expReady, input logic [1:0] expGrant,
                               input logic doClr = 1'b0);
    exp_t e;
    @(negedge clk_i);
    tx_req_i  = 1'b1;
    tx_lr_i   = lr;
    udr_clr_i = doClr;
    e.data    = expData;
    e.due     = cycCount + 1;
    sbQ.push_back(e);
    #1;
    checkOutput("src_ready", 64'(src_ready_o), 64'(expReady));
    @(negedge clk_i);
    tx_req_i  = 1'b0;
    udr_clr_i = 1'b0;
    checkOutput("grant", 64'(grant_o), 64'(expGrant));
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    en_i        = 1'b1;
    mode_i      = 1'b0;
    src_en_i    = 2'b11;
    src_valid_i = 2'b00;
    src_data_i  = {S1R, S1L, S0R, S0L};
    tx_req_i    = 1'b0;
    tx_lr_i     = 1'b0;
    udr_clr_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_tx_dat", 64'(tx_dat_o), 64'd0);
    checkOutput("rst_tx_vld", 64'(tx_vld_o), 64'd0);
    checkOutput("rst_grant", 64'(grant_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_udr", 64'(udr_cnt_o), 64'd0);
    checkOutput("rst_ready", 64'(src_ready_o), 64'd0);
    rst_i = 1'b0;

    $display("[TB] basic frame");
    src_valid_i = 2'b01;
    applyStimulus(1'b0, S0L, 2'b01, 2'b01);
    checkOutput("busy_hold_r", 64'(busy_o), 64'd1);
    applyStimulus(1'b1, S0R, 2'b00, 2'b00);
    checkOutput("busy_idle", 64'(busy_o), 64'd0);
    checkOutput("udr_basic", 64'(udr_cnt_o), 64'd0);

    $display("[TB] round-robin then fixed priority");
    doReset();
    src_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        applyStimulus(1'b0, S0L, 2'b01, 2'b01);
        applyStimulus(1'b1, S0R, 2'b00, 2'b00);
      end else begin
        applyStimulus(1'b0, S1L, 2'b10, 2'b10);
        applyStimulus(1'b1, S1R, 2'b00, 2'b00);
      end
    end
    mode_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, S0L, 2'b01, 2'b01);
      applyStimulus(1'b1, S0R, 2'b00, 2'b00);
    end
    checkOutput("udr_rr", 64'(udr_cnt_o), 64'd0);

    $display("[TB] underrun");
    mode_i      = 1'b0;
    src_valid_i = 2'b00;
    applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
    applyStimulus(1'b1, 32'd0, 2'b00, 2'b00);
    checkOutput("udr_first", 64'(udr_cnt_o), 64'd1);
    src_valid_i = 2'b10;
    src_en_i    = 2'b01;
    applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
    applyStimulus(1'b1, 32'd0, 2'b00, 2'b00);
    checkOutput("udr_masked", 64'(udr_cnt_o), 64'd2);
    src_en_i = 2'b11;

    $display("[TB] resync");
    src_valid_i = 2'b11;
    applyStimulus(1'b0, S1L, 2'b10, 2'b10);
    applyStimulus(1'b0, S0L, 2'b01, 2'b01);
    checkOutput("udr_resync", 64'(udr_cnt_o), 64'd3);
    applyStimulus(1'b1, S0R, 2'b00, 2'b00);

    $display("[TB] counter saturation and clear");
    @(negedge clk_i);
    udr_clr_i = 1'b1;
    @(negedge clk_i);
    udr_clr_i = 1'b0;
    checkOutput("udr_clear", 64'(udr_cnt_o), 64'd0);
    src_valid_i = 2'b00;
    for (int k = 0; k < 17; k++) applyStimulus(1'b1, 32'd0, 2'b00, 2'b00);
    checkOutput("udr_saturate", 64'(udr_cnt_o), 64'd15);
    applyStimulus(1'b1, 32'd0, 2'b00, 2'b00, 1'b1);
    checkOutput("udr_clr_inc", 64'(udr_cnt_o), 64'd1);

    $display("[TB] reset during HOLD_R");
    src_valid_i = 2'b01;
    applyStimulus(1'b0, S0L, 2'b01, 2'b01);
    @(negedge clk_i);
    rst_i    = 1'b1;
    tx_req_i = 1'b1;
    tx_lr_i  = 1'b1;
    #1;
    checkOutput("ready_in_reset", 64'(src_ready_o), 64'd0);
    @(negedge clk_i);
    rst_i    = 1'b0;
    tx_req_i = 1'b0;
    checkOutput("post_rst_tx_dat", 64'(tx_dat_o), 64'd0);
    checkOutput("post_rst_vld", 64'(tx_vld_o), 64'd0);
    checkOutput("post_rst_grant", 64'(grant_o), 64'd0);
    checkOutput("post_rst_busy", 64'(busy_o), 64'd0);
    checkOutput("post_rst_udr", 64'(udr_cnt_o), 64'd0);
    applyStimulus(1'b1, 32'd0, 2'b00, 2'b00);
    checkOutput("udr_orphan", 64'(udr_cnt_o), 64'd1);

    $display("[TB] enable low");
    src_valid_i = 2'b11;
    applyStimulus(1'b0, S0L, 2'b01, 2'b01);
    en_i = 1'b0;
    applyStimulus(1'b1, 32'd0, 2'b00, 2'b00);
    applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
    checkOutput("udr_disabled", 64'(udr_cnt_o), 64'd1);
    en_i = 1'b1;
    applyStimulus(1'b1, 32'd0, 2'b00, 2'b00);
    checkOutput("udr_dropped", 64'(udr_cnt_o), 64'd2);

    repeat (3) @(negedge clk_i);
    checkOutput("queue_drain", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sched.md
Name: i2s_tx_sched

Overview:
Transmit-side scheduler that shares one I2S transmitter between NUM_SRC stereo sample producers. It answers per-slot word requests from the I2S core. Ownership is granted per stereo frame (left+right pair) by round-robin or fixed priority. When no producer has a frame ready, it inserts silence and counts underruns. It sits between the APB-configured I2S core TX path and the audio sources (DMA/CPU FIFOs).

Parameters:
NUM_SRC, 2, number of sample producers (1..8)
DATA_WIDTH, 32, width of one channel word
CNT_WIDTH, 16, width of saturating underrun counter

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  scheduler enable
mode_i  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
src_en_i  in  NUM_SRC  per-source enable mask
src_valid_i  in  NUM_SRC  source i has a stereo frame ready
src_data_i  in  NUM_SRC*2*DATA_WIDTH  frame of source i at [i*2*DW +: 2*DW]; low DW = left, high DW = right
src_ready_o  out  NUM_SRC  one-cycle accept pulse; frame consumed when valid & ready
tx_req_i  in  1  one-cycle pulse from I2S core: next word needed
tx_lr_i  in  1  slot of the request: 0 = left, 1 = right; sampled with tx_req_i
tx_dat_o  out  DATA_WIDTH  word returned to I2S core
tx_vld_o  out  1  one-cycle pulse qualifying tx_dat_o
grant_o  out  NUM_SRC  one-hot owner of the current frame; 0 when none
busy_o  out  1  high while in HOLD_R
udr_cnt_o  out  CNT_WIDTH  saturating underrun count
udr_clr_i  in  1  clears udr_cnt_o

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; rr pointer 0; frame latch 0; udr_cnt_o 0. All outputs 0: tx_dat_o, tx_vld_o, src_ready_o, grant_o, busy_o.
- Eligible set E = src_en_i & src_valid_i.
- Winner selection:
  - mode_i=1: lowest set index of E.
  - mode_i=0: first set index of E at or after rr pointer, searching cyclically with wrap NUM_SRC-1 -> 0.
- Response latency: every tx_req_i yields exactly one tx_vld_o pulse on the next cycle. tx_dat_o is valid in that cycle and holds its value until the next response.
- FSM states:
  - IDLE, tx_req_i & !tx_lr_i, E != 0:
    - Latch the winner's frame; pulse src_ready_o[w] in the same cycle.
    - Next cycle: tx_dat_o = left word, grant_o = onehot(w).
    - rr pointer = (w+1) mod NUM_SRC, updated in both modes.
    - Go to HOLD_R.
  - IDLE, tx_req_i & !tx_lr_i, E == 0 (underrun):
    - Respond with 0; udr_cnt_o += 1.
    - Go to HOLD_Z, so the matching right slot also outputs 0. No source is acked.
  - IDLE, tx_req_i & tx_lr_i (orphan right slot): respond with 0; udr_cnt_o += 1; stay IDLE.
  - HOLD_R, tx_req_i & tx_lr_i:
    - Respond with the latched right word.
    - grant_o clears in the response cycle. Go to IDLE.
  - HOLD_R, tx_req_i & !tx_lr_i (resync, right slot missed):
    - Discard the latched right word; udr_cnt_o += 1.
    - Treat the request as a fresh IDLE left request in the same cycle (new arbitration).
  - HOLD_Z, tx_req_i & tx_lr_i: respond 0, go to IDLE, no count.
  - HOLD_Z, left request: handle as an IDLE left request.
  - No tx_req_i in any state: state holds; src_ready_o = 0.
- src_ready_o is never asserted for a source outside E, and never more than one bit per cycle.
- Source data is sampled only in the accept cycle. Changes to src_valid_i or src_data_i while in HOLD_R have no effect on the pair being played.
- en_i=0:
  - Forces IDLE; grant_o = 0; no src_ready_o.
  - tx_req_i still gets a one-cycle-later response with tx_dat_o = 0.
  - udr_cnt_o does not count.
  - A frame already latched is dropped.
- udr_cnt_o:
  - Saturates at all-ones.
  - udr_clr_i with no increment -> 0.
  - udr_clr_i together with an increment in the same cycle -> 1.
- rst_i mid-frame (in HOLD_R) overrides everything. Next cycle: IDLE, outputs 0, no response to a tx_req_i sampled during reset.
- tx_req_i pulses are guaranteed at least 2 cycles apart. Behaviour for back-to-back requests is unspecified.

Test Plan:
- Basic frame: NUM_SRC=2, src0 valid, frame L=0x11111111/R=0x22222222, requests L then R -> src_ready_o=01 in the L request cycle; tx_vld_o pulses next cycle carrying 0x11111111, then 0x22222222; grant_o=01 between the two; udr_cnt_o=0.
- Round-robin: both sources always valid, 4 frames in mode_i=0 -> grants 01,10,01,10. Repeat with mode_i=1 -> grants 01 every frame.
- Underrun: no source valid, L+R requests -> tx_dat_o=0 for both slots; udr_cnt_o=1; src_ready_o never asserted. Then src1 valid with src_en_i=01 -> still silence; udr_cnt_o=2.
- Resync: accept a frame, then issue a second left request instead of a right -> udr_cnt_o increments; new arbitration acks the next source; the dropped right word never appears on tx_dat_o.
- Counter edges: force CNT_WIDTH=4, 17 underruns -> udr_cnt_o=15. Then udr_clr_i coincident with an underrun -> 1.
- Reset/enable: assert rst_i in HOLD_R -> all outputs 0 next cycle; the following right request outputs 0 and counts an underrun. en_i=0 -> responses are 0, no count, no src_ready_o.
